// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: preamble MSB-first, payload MSB-first, optional parity (SEQ_PATTERN_TX_PARITY_EN).
// Latency: first bit one cycle after the handshake. in_ready stays low for the whole frame, so frames are separated by at least one idle bit.
module seq_pattern_tx #(
    parameter int                    DATA_W     = 8,
    parameter int                    PREAMBLE_W = 4,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 4'b0111,
    parameter logic                  IDLE_BIT   = 1'b0,
    parameter int                    CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              x_out,
    output logic              x_valid,
    output logic              x_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int MAX_W = (PREAMBLE_W > DATA_W) ? PREAMBLE_W : DATA_W;
    localparam int CW    = ($clog2(MAX_W) > 0) ? $clog2(MAX_W) : 1;
    localparam logic [PREAMBLE_W-1:0] PRE_V = PREAMBLE;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam logic [1:0] S_PAR  = 2'd3;
    logic par_q, par_d;
`endif

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [PREAMBLE_W-1:0] pre_q, pre_d;
    logic                  x_out_q, x_out_d;
    logic                  x_valid_q, x_valid_d;
    logic                  x_last_q, x_last_d;
    logic [CNT_W-1:0]      frames_q, frames_d;

    // x_* registers hold the bit for the *next* cycle, so each branch loads what the upcoming cycle shows.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        pre_d     = pre_q;
        x_out_d   = x_out_q;
        x_valid_d = x_valid_q;
        x_last_d  = 1'b0;
        frames_d  = frames_q + {{(CNT_W-1){1'b0}}, x_last_q};
`ifdef SEQ_PATTERN_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                x_valid_d = 1'b0;
                x_out_d   = IDLE_BIT;
                if (in_valid) begin
                    state_d   = S_PRE;
                    cnt_d     = CW'(PREAMBLE_W - 1);
                    shift_d   = in_data;
                    pre_d     = PRE_V << 1;
                    x_out_d   = PRE_V[PREAMBLE_W-1];
                    x_valid_d = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    par_d     = ^in_data;
`endif
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = CW'(DATA_W - 1);
                    x_out_d = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
`ifndef SEQ_PATTERN_TX_PARITY_EN
                    x_last_d = (DATA_W == 1);
`endif
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    x_out_d = pre_q[PREAMBLE_W-1];
                    pre_d   = pre_q << 1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_d  = S_PAR;
                    x_out_d  = par_q;
                    x_last_d = 1'b1;
`else
                    state_d   = S_IDLE;
                    x_valid_d = 1'b0;
                    x_out_d   = IDLE_BIT;
`endif
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    x_out_d = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
`ifndef SEQ_PATTERN_TX_PARITY_EN
                    x_last_d = (cnt_q == CW'(1));
`endif
                end
            end
            default: begin
                state_d   = S_IDLE;
                x_valid_d = 1'b0;
                x_out_d   = IDLE_BIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            pre_q     <= '0;
            x_out_q   <= IDLE_BIT;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
            frames_q  <= '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            pre_q     <= pre_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            x_last_q  <= x_last_d;
            frames_q  <= frames_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = ~in_ready;
    assign x_out       = x_out_q;
    assign x_valid     = x_valid_q;
    assign x_last      = x_last_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: driver queues expected frame bits, a negedge monitor pops and compares.
module tb_seq_pattern_tx;

    localparam int DW = 8;
    localparam int PW = 4;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int L = PW + DW + (PAR ? 1 : 0);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          x_out, x_valid, x_last, busy;
    logic [3:0]    frames_sent;

    seq_pattern_tx #(.DATA_W(DW), .PREAMBLE_W(PW), .PREAMBLE(4'b0111),
                     .IDLE_BIT(1'b0), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .x_out(x_out), .x_valid(x_valid), .x_last(x_last),
        .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [1:0] exp_q[$];
    logic [PW-1:0] pre_v = 4'b0111;
    logic [3:0] exp_frames = '0;
    int         gap = 0;
    int         last_gap = 0;
    bit         prev_vld = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every frame bit must match the head of the expected queue.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset) begin
            if (x_valid) begin
                if (!prev_vld) begin
                    last_gap = gap;
                    gap = 0;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 16'(x_valid), 16'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("x_out", 16'(x_out), 16'(e[1]));
                    chk("x_last", 16'(x_last), 16'(e[0]));
                end
            end else begin
                gap++;
                chk("idle_x_out", 16'(x_out), 16'd0);
                chk("idle_x_last", 16'(x_last), 16'd0);
            end
            prev_vld = x_valid;
        end else begin
            prev_vld = 1'b0;
        end
    end

    task automatic send(input logic [DW-1:0] w, input bit keep);
        int n;
        for (int i = PW - 1; i >= 0; i--) exp_q.push_back({pre_v[i], 1'b0});
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back({w[i], (!PAR && i == 0)});
        if (PAR) exp_q.push_back({^w, 1'b1});
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 16'(n >= 200), 16'd0);
        @(posedge clk);
        #1;
        if (!keep) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || x_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 16'(n >= 200), 16'd0);
        exp_frames = exp_frames + 4'd1;
    endtask

    initial begin
        #12;
        chk("rst_x_out", 16'(x_out), 16'd0);
        chk("rst_x_valid", 16'(x_valid), 16'd0);
        chk("rst_x_last", 16'(x_last), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_frames", 16'(frames_sent), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic frame: in_ready low for every bit cycle.
        send(8'hA5, 1'b0);
        repeat (L) begin
            @(negedge clk);
            chk("busy_in_ready", 16'(in_ready), 16'd0);
        end
        wait_done();
        chk("frames_after_1", 16'(frames_sent), 16'(exp_frames));

        // Back-to-back with in_valid held: exactly one idle cycle between frames.
        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        wait_done();
        exp_frames = exp_frames + 4'd1;
        chk("b2b_gap", 16'(last_gap), 16'd1);
        chk("frames_b2b", 16'(frames_sent), 16'(exp_frames));

        // Reset mid-frame during a data bit.
        send(8'hA5, 1'b0);
        repeat (8) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_x_valid", 16'(x_valid), 16'd0);
        chk("midrst_x_out", 16'(x_out), 16'd0);
        chk("midrst_in_ready", 16'(in_ready), 16'd1);
        chk("midrst_frames", 16'(frames_sent), 16'd0);
        exp_q.delete();
        exp_frames = '0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        send(8'h3C, 1'b0);
        wait_done();
        chk("frames_after_rst", 16'(frames_sent), 16'(exp_frames));

        // Handshake hygiene: junk on in_valid/in_data while busy.
        send(8'h5A, 1'b0);
        repeat (L - 2) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        chk("hygiene_no_extra", 16'(exp_q.size()), 16'd0);
        chk("frames_hygiene", 16'(frames_sent), 16'(exp_frames));

        // Counter wrap with a 4-bit counter.
        for (int i = 0; i < 13; i++) begin
            send(DW'(i * 37 + 1), 1'b0);
            wait_done();
        end
        chk("frames_15", 16'(frames_sent), 16'd15);
        send(8'h81, 1'b0);
        wait_done();
        chk("frames_wrap", 16'(frames_sent), 16'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
